// File: rtl/lane_regfile_if.sv
// Issue, writeback and read-port bundle between the scheduler, the per-lane ALUs
// and the multi-lane register file. Lane i occupies slice [i*W +: W] of each field.
interface lane_regfile_if #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int NREGS     = 32
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_LANES*AW-1:0]   rd_addr_a;
  logic [NUM_LANES*AW-1:0]   rd_addr_b;
  logic [NUM_LANES*XLEN-1:0] rd_data_a;
  logic [NUM_LANES*XLEN-1:0] rd_data_b;
  logic [NUM_LANES-1:0]      rd_busy_a;
  logic [NUM_LANES-1:0]      rd_busy_b;
  logic [NUM_LANES-1:0]      wr_en;
  logic [NUM_LANES*AW-1:0]   wr_addr;
  logic [NUM_LANES*XLEN-1:0] wr_data;
  logic [NUM_LANES-1:0]      issue_en;
  logic [NUM_LANES*AW-1:0]   issue_rd;
  logic                      wr_collide;
  logic                      wb_err;
  logic [NREGS-1:0]          busy_vec;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, wr_collide, wb_err, busy_vec
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, wr_collide, wb_err, busy_vec
  );
endinterface

// File: rtl/lane_regfile.sv
// Multi-lane integer register file with issue scoreboard, write-collision
// priority (highest lane wins), optional write-to-read bypass and sticky wb_err.
module lane_regfile #(
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int BYPASS    = 1
) (
  input logic           clk,
  input logic           rst,
  lane_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int NP = 2 * NUM_LANES;

  logic [XLEN-1:0]      mem [NREGS];
  logic [NREGS-1:0]     busy;
  logic                 wb_err_q;
  logic [NUM_LANES-1:0] wr_act;
  logic [NREGS-1:0]     set_vec;
  logic [NREGS-1:0]     clr_vec;
  logic [NREGS-1:0]     busy_nxt;
  logic                 err_hit;
  logic [AW-1:0]        raddr [NP];
  logic [XLEN-1:0]      rdata [NP];
  logic [NP-1:0]        rbusy;

  // Writes to x0 are dropped here so they never bypass, collide or clear busy;
  // while reset is held no write is considered live.
  always_comb begin
    wr_act = '0;
    for (int i = 0; i < NUM_LANES; i++)
      wr_act[i] = rst && bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] != '0);
  end

  always_comb begin
    bus.wr_collide = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = i + 1; j < NUM_LANES; j++)
        if (wr_act[i] && wr_act[j] && (bus.wr_addr[i*AW +: AW] == bus.wr_addr[j*AW +: AW]))
          bus.wr_collide = 1'b1;
  end

  // A same-cycle issue outranks the writeback, so set wins over clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    err_hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.issue_en[i]) set_vec[bus.issue_rd[i*AW +: AW]] = 1'b1;
      if (wr_act[i])       clr_vec[bus.wr_addr[i*AW +: AW]]  = 1'b1;
    end
    set_vec[0] = 1'b0;
    clr_vec[0] = 1'b0;
    busy_nxt = set_vec | (busy & ~clr_vec);
    for (int i = 0; i < NUM_LANES; i++)
      if (wr_act[i] && !busy[bus.wr_addr[i*AW +: AW]] && !set_vec[bus.wr_addr[i*AW +: AW]])
        err_hit = 1'b1;
  end

  // Ascending lane order makes the youngest (highest) lane's write land last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      wb_err_q <= 1'b0;
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      busy <= busy_nxt;
      if (err_hit) wb_err_q <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++)
        if (wr_act[i]) mem[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      raddr[l]             = bus.rd_addr_a[l*AW +: AW];
      raddr[NUM_LANES + l] = bus.rd_addr_b[l*AW +: AW];
    end
  end

  // Ports 0..N-1 are port A lanes, N..2N-1 are port B lanes.
  always_comb begin
    rbusy = '0;
    for (int p = 0; p < NP; p++) begin
      rdata[p] = mem[raddr[p]];
      rbusy[p] = busy[raddr[p]];
      if (BYPASS != 0)
        for (int w = 0; w < NUM_LANES; w++)
          if (wr_act[w] && (bus.wr_addr[w*AW +: AW] == raddr[p])) begin
            rdata[p] = bus.wr_data[w*XLEN +: XLEN];
            rbusy[p] = 1'b0;
          end
    end
  end

  always_comb begin
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    bus.rd_busy_a = '0;
    bus.rd_busy_b = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      bus.rd_data_a[l*XLEN +: XLEN] = rdata[l];
      bus.rd_data_b[l*XLEN +: XLEN] = rdata[NUM_LANES + l];
      bus.rd_busy_a[l]              = rbusy[l];
      bus.rd_busy_b[l]              = rbusy[NUM_LANES + l];
    end
  end

  assign bus.wb_err   = wb_err_q;
  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_lane_regfile.sv
// Scoreboard bench: a BYPASS=1 and a BYPASS=0 register file share one stimulus
// stream; a reference model predicts both, a negedge monitor checks them.
module tb_lane_regfile;
  localparam int NL = 3;
  localparam int XL = 32;
  localparam int NR = 32;
  localparam int AW = $clog2(NR);

  logic clk, rst;
  logic [NL*AW-1:0] rd_addr_a, rd_addr_b, wr_addr, issue_rd;
  logic [NL-1:0]    wr_en, issue_en;
  logic [NL*XL-1:0] wr_data;

  typedef struct {
    logic [NL*XL-1:0] rda;
    logic [NL*XL-1:0] rdb;
    logic [NL-1:0]    ba;
    logic [NL-1:0]    bb;
    logic             col;
    logic [NR-1:0]    bv;
    logic             err;
  } exp_t;

  typedef struct {
    exp_t byp;
    exp_t nbp;
  } pair_t;

  pair_t q[$];
  pair_t mon_p;

  logic [XL-1:0] m_mem [NR];
  logic [NR-1:0] m_busy;
  logic          m_err;
  int n_vec = 0, n_cmp = 0, n_miss = 0;

  lane_regfile_if #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR)) if_b ();
  lane_regfile_if #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR)) if_n ();

  assign if_b.rd_addr_a = rd_addr_a;
  assign if_b.rd_addr_b = rd_addr_b;
  assign if_b.wr_en     = wr_en;
  assign if_b.wr_addr   = wr_addr;
  assign if_b.wr_data   = wr_data;
  assign if_b.issue_en  = issue_en;
  assign if_b.issue_rd  = issue_rd;
  assign if_n.rd_addr_a = rd_addr_a;
  assign if_n.rd_addr_b = rd_addr_b;
  assign if_n.wr_en     = wr_en;
  assign if_n.wr_addr   = wr_addr;
  assign if_n.wr_data   = wr_data;
  assign if_n.issue_en  = issue_en;
  assign if_n.issue_rd  = issue_rd;

  lane_regfile #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  lane_regfile #(.NUM_LANES(NL), .XLEN(XL), .NREGS(NR), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] wa(int i);
    return wr_addr[i*AW +: AW];
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NR; r++) m_mem[r] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endfunction

  // Read port: newest (highest-lane) live write to the address, else stored value.
  function automatic void port_val(input logic [AW-1:0] a, input bit byp,
                                   output logic [XL-1:0] d, output logic b);
    int w = -1;
    if (rst && byp && a != 0)
      for (int j = NL - 1; j >= 0; j--)
        if (w < 0 && wr_en[j] && wa(j) == a) w = j;
    if (a == 0)      d = '0;
    else if (w >= 0) d = wr_data[w*XL +: XL];
    else             d = m_mem[a];
    b = (a != 0) && m_busy[a] && (w < 0);
  endfunction

  function automatic exp_t model_out(bit byp);
    exp_t e;
    logic [XL-1:0] d;
    logic b;
    e.col = 1'b0;
    if (rst)
      for (int i = 0; i < NL; i++)
        for (int j = i + 1; j < NL; j++)
          if (wr_en[i] && wr_en[j] && wa(i) != 0 && wa(i) == wa(j)) e.col = 1'b1;
    for (int l = 0; l < NL; l++) begin
      port_val(rd_addr_a[l*AW +: AW], byp, d, b);
      e.rda[l*XL +: XL] = d;
      e.ba[l] = b;
      port_val(rd_addr_b[l*AW +: AW], byp, d, b);
      e.rdb[l*XL +: XL] = d;
      e.bb[l] = b;
    end
    e.bv  = m_busy;
    e.err = m_err;
    return e;
  endfunction

  function automatic void edge_update();
    bit [NR-1:0] set_r, clr_r;
    bit younger;
    set_r = '0;
    clr_r = '0;
    for (int i = 0; i < NL; i++) begin
      if (issue_en[i] && issue_rd[i*AW +: AW] != 0) set_r[issue_rd[i*AW +: AW]] = 1'b1;
      if (wr_en[i] && wa(i) != 0) clr_r[wa(i)] = 1'b1;
    end
    for (int i = 0; i < NL; i++)
      if (wr_en[i] && wa(i) != 0 && !m_busy[wa(i)] && !set_r[wa(i)]) m_err = 1'b1;
    for (int i = 0; i < NL; i++) begin
      younger = 1'b0;
      for (int j = i + 1; j < NL; j++)
        if (wr_en[j] && wa(j) == wa(i)) younger = 1'b1;
      if (wr_en[i] && wa(i) != 0 && !younger) m_mem[wa(i)] = wr_data[i*XL +: XL];
    end
    for (int r = 0; r < NR; r++)
      if (set_r[r])      m_busy[r] = 1'b1;
      else if (clr_r[r]) m_busy[r] = 1'b0;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_p = q.pop_front();
      cmp("byp rd_data_a", 128'(if_b.rd_data_a), 128'(mon_p.byp.rda));
      cmp("byp rd_data_b", 128'(if_b.rd_data_b), 128'(mon_p.byp.rdb));
      cmp("byp rd_busy_a", 128'(if_b.rd_busy_a), 128'(mon_p.byp.ba));
      cmp("byp rd_busy_b", 128'(if_b.rd_busy_b), 128'(mon_p.byp.bb));
      cmp("byp wr_collide", 128'(if_b.wr_collide), 128'(mon_p.byp.col));
      cmp("byp busy_vec", 128'(if_b.busy_vec), 128'(mon_p.byp.bv));
      cmp("byp wb_err", 128'(if_b.wb_err), 128'(mon_p.byp.err));
      cmp("nbp rd_data_a", 128'(if_n.rd_data_a), 128'(mon_p.nbp.rda));
      cmp("nbp rd_data_b", 128'(if_n.rd_data_b), 128'(mon_p.nbp.rdb));
      cmp("nbp rd_busy_a", 128'(if_n.rd_busy_a), 128'(mon_p.nbp.ba));
      cmp("nbp rd_busy_b", 128'(if_n.rd_busy_b), 128'(mon_p.nbp.bb));
      cmp("nbp wr_collide", 128'(if_n.wr_collide), 128'(mon_p.nbp.col));
      cmp("nbp busy_vec", 128'(if_n.busy_vec), 128'(mon_p.nbp.bv));
      cmp("nbp wb_err", 128'(if_n.wb_err), 128'(mon_p.nbp.err));
    end
  end

  // Inputs are already driven when this is called (just after a rising edge).
  task automatic step();
    pair_t p;
    if (!rst) model_clear();
    p.byp = model_out(1'b1);
    p.nbp = model_out(1'b0);
    q.push_back(p);
    n_vec++;
    @(posedge clk);
    if (rst) edge_update();
    #1;
  endtask

  task automatic idle();
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; issue_rd = '0;
    wr_en = '0; issue_en = '0; wr_data = '0;
  endtask

  task automatic set_wr(input int l, input int a, input logic [XL-1:0] d);
    wr_en[l] = 1'b1;
    wr_addr[l*AW +: AW] = AW'(a);
    wr_data[l*XL +: XL] = d;
  endtask

  task automatic set_iss(input int l, input int a);
    issue_en[l] = 1'b1;
    issue_rd[l*AW +: AW] = AW'(a);
  endtask

  task automatic set_rd(input int l, input int a, input int b);
    rd_addr_a[l*AW +: AW] = AW'(a);
    rd_addr_b[l*AW +: AW] = AW'(b);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_clear();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    for (int a = 0; a < NR; a++) begin
      for (int l = 0; l < NL; l++) set_rd(l, a, NR - 1 - a);
      step();
    end

    // x0 is never written nor busy
    idle(); set_wr(0, 0, 32'hFF); set_iss(1, 0); set_rd(2, 0, 0); step();
    idle(); set_rd(0, 0, 0); step();

    // scoreboard: issue, writeback racing a reissue, final writeback
    idle(); set_iss(0, 3); step();
    idle(); set_rd(0, 1, 3); step();
    idle(); set_wr(0, 3, 32'h0000_3333); set_iss(1, 3); set_rd(1, 3, 3); step();
    idle(); set_rd(0, 3, 3); step();
    idle(); set_wr(0, 3, 32'h0000_4444); set_rd(2, 3, 3); step();
    idle(); set_rd(0, 3, 3); step();

    // bypass of a same-cycle write
    idle(); set_iss(0, 5); set_iss(1, 7); step();
    idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(1, 5, 0); step();
    idle(); set_rd(1, 5, 0); step();

    // collision: highest lane wins
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(2, 7, 7); step();
    idle(); set_rd(0, 7, 7); step();

    // writeback to a register that was never issued
    idle(); set_wr(0, 9, 32'h9999); step();
    idle(); set_rd(0, 9, 9); step();
    step();

    // reset asserted mid-operation
    idle(); set_iss(0, 4); set_iss(1, 6); step();
    idle(); set_rd(0, 4, 6); step();
    rst = 1'b0; step();
    rst = 1'b1; idle(); set_rd(0, 4, 6); set_rd(1, 9, 7); step();

    for (int k = 0; k < 500; k++) begin
      wr_en    = NL'($urandom);
      issue_en = NL'($urandom);
      wr_data  = {$urandom, $urandom, $urandom};
      for (int l = 0; l < NL; l++) begin
        wr_addr[l*AW +: AW]   = AW'($urandom_range(0, 7));
        issue_rd[l*AW +: AW]  = AW'($urandom_range(0, 7));
        rd_addr_a[l*AW +: AW] = AW'($urandom_range(0, 7));
        rd_addr_b[l*AW +: AW] = AW'($urandom_range(0, NR - 1));
      end
      if (k == 250) rst = 1'b0;
      if (k == 251) rst = 1'b1;
      step();
    end

    idle();
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/lane_regfile.md
Name: lane_regfile

Overview:
- Parametrised multi-lane integer register file with an integrated issue scoreboard for the N-wide issue datapath.
- Generalises the two-lane register file to NUM_LANES lanes. Each lane has 2 read ports and 1 write port.
- Adds behaviour the two-lane file lacks: write-collision priority, optional write-to-read bypass, per-register busy tracking, and a sticky writeback-error flag.
- Sits between the scheduling assistant (issue side) and the per-lane ALUs (writeback side).

Parameters:
- NUM_LANES, 2, number of issue lanes (1..4).
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of 2). AW = $clog2(NREGS).
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads return pre-edge contents.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rd_addr_a  in  NUM_LANES*AW  read port A address, lane i at bits [i*AW +: AW]
- rd_addr_b  in  NUM_LANES*AW  read port B address, same packing
- rd_data_a  out  NUM_LANES*XLEN  port A data, combinational
- rd_data_b  out  NUM_LANES*XLEN  port B data, combinational
- rd_busy_a  out  NUM_LANES  port A source register has a pending write
- rd_busy_b  out  NUM_LANES  port B source register has a pending write
- wr_en  in  NUM_LANES  writeback valid per lane
- wr_addr  in  NUM_LANES*AW  writeback destination
- wr_data  in  NUM_LANES*XLEN  writeback data
- issue_en  in  NUM_LANES  lane issued an instruction that writes a register
- issue_rd  in  NUM_LANES*AW  destination of the issued instruction
- wr_collide  out  1  combinational: two or more enabled writes target the same nonzero register this cycle
- wb_err  out  1  sticky: writeback seen to a register that was not busy
- busy_vec  out  NREGS  current scoreboard state, bit 0 always 0

Behaviour:
- Reset (rst low, asynchronous):
  - all registers clear to 0, all busy bits clear to 0, wb_err clears to 0.
  - rst low mid-operation discards every pending write and busy bit immediately.
  - Combinational outputs follow the cleared state while rst is low.
- Register x0:
  - always reads 0 and is never busy.
  - writes, issues and writebacks to x0 are ignored; they never set wb_err and never count toward wr_collide.
- Writes:
  - take effect on the rising clk edge; latency is 1 cycle for BYPASS=0 and 0 cycles (same-cycle visible) for BYPASS=1.
  - Collision, several lanes enabled to the same address: the highest-numbered lane wins, because the higher lane is younger in program order. wr_collide is high during that cycle.
- Read data:
  - BYPASS=1: if any enabled write targets the read address, output that write's data, using the same highest-lane priority. Otherwise output the array contents.
  - BYPASS=0: always output the array contents.
  - Reads are purely combinational; there is no read enable.
- Scoreboard, with per-register next state:
  - set = any issue_en lane targets r.
  - clr = any wr_en lane targets r.
  - set and clr in the same cycle: busy stays 1, because the new issue supersedes the writeback.
  - clr only: busy goes to 0.
  - set only: busy goes to 1.
  - Issuing to a register that is already busy is legal; busy stays 1 (single bit, no count).
- rd_busy_a/b:
  - equal to busy[addr] before the edge, masked to 0 when BYPASS=1 and a same-cycle enabled write targets addr. The forwarded data resolves the hazard.
  - When BYPASS=0, a same-cycle writeback does not clear rd_busy that cycle.
- wb_err:
  - set at the edge when any enabled nonzero wr_addr has busy=0 before the edge and no same-cycle issue to it.
  - stays 1 until reset.
- busy_vec shows the registered busy bits only, with no bypass masking.
- Widths: addresses are unsigned. For NREGS a power of 2, every address is in range. Data is stored verbatim with no extension.

Test Plan:
- Reset then read: hold rst low, release, read all addresses on every lane → all rd_data 0, busy_vec 0, wb_err 0.
- Bypass: BYPASS=1, lane0 writes x5=0xDEADBEEF while lane1 port A reads x5 in the same cycle → rd_data_a[1]=0xDEADBEEF that cycle. With BYPASS=0 the same stimulus gives 0 that cycle and 0xDEADBEEF the next cycle.
- Collision: lane0 writes x7=0x11 and lane1 writes x7=0x22 together → wr_collide=1 that cycle, and x7 reads 0x22 afterwards.
- Scoreboard:
  - issue x3 on lane0 → busy_vec[3]=1 next cycle, rd_busy_b=1 for a reader of x3.
  - writeback x3 with an issue to x3 on lane1 in the same cycle → busy stays 1.
  - a later writeback with no issue → busy_vec[3]=0.
- x0 and errors:
  - write x0=0xFF and issue x0 → x0 reads 0, busy_vec[0]=0, wb_err=0.
  - writeback x9 while it is not busy → wb_err=1 and stays 1 until rst.
- Reset mid-operation: issue x4 and x6, then assert rst for 1 cycle between edges → busy_vec is 0 immediately and registers read 0.
